// File: rtl/pipe_fetch.sv
// rtl/pipe_fetch.sv - instruction fetch stage with IF/ID pipeline register
//
// Fetches one instruction at a time from a variable-latency instruction
// memory and hands it to decode through the IF/ID register. A redirect that
// arrives before the branch delay slot has been delivered is parked until
// the delay slot goes through, so the delay slot is always executed.
//
// Ports:
//   clock, resetn        system clock, asynchronous active-low reset
//   pcsource             next-PC select: 00 pc+4, 01 bpc, 10 da, 11 jpc
//   bpc, jpc, da         redirect targets from decode
//   wpcir                0 = decode stalled, hold pc and IF/ID
//   imem_req/addr/gnt    fetch request handshake (req & gnt)
//   imem_rvalid/rdata    fetch response, one per granted request
//   pc                   address currently being fetched
//   dpc4, inst, dvalid   IF/ID register contents

module pipe_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] jpc,
    input  logic [31:0] da,
    input  logic        wpcir,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] dpc4,
    output logic [31:0] inst,
    output logic        dvalid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic [31:0] inst_q, inst_d;
    logic        dvalid_q, dvalid_d;
    logic [31:0] hold_q, hold_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;

    logic        deliver;
    logic        redir_now;
    logic [31:0] word;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic [31:0] next_pc;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;

        case (pcsource)
            2'b01:   target = bpc;
            2'b10:   target = da;
            2'b11:   target = jpc;
            default: target = pc_plus4;
        endcase

        // A word goes to decode either straight from memory or from the
        // hold buffer, and only when decode is ready to take it.
        deliver = wpcir && (((state_q == S_WAIT) && imem_rvalid) || (state_q == S_HOLD));
        word    = (state_q == S_HOLD) ? hold_q : imem_rdata;

        // Decode keeps a bubble until the delay slot arrives, so a second
        // redirect while one is parked cannot be legitimate; drop it.
        redir_now = wpcir && (pcsource != 2'b00) && !redir_pend_q;

        if (redir_now)         next_pc = target;
        else if (redir_pend_q) next_pc = redir_tgt_q;
        else                   next_pc = pc_plus4;

        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        if (deliver) begin
            // This delivery is the delay slot; any redirect is consumed here.
            redir_pend_d = 1'b0;
        end else if (redir_now) begin
            redir_pend_d = 1'b1;
            redir_tgt_d  = target;
        end

        pc_d = deliver ? next_pc : pc_q;

        dpc4_d   = dpc4_q;
        inst_d   = inst_q;
        dvalid_d = dvalid_q;
        if (wpcir) begin
            if (deliver) begin
                dpc4_d   = pc_plus4;
                inst_d   = word;
                dvalid_d = 1'b1;
            end else begin
                inst_d   = 32'h0;
                dvalid_d = 1'b0;
            end
        end

        hold_d  = hold_q;
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (req_q && imem_gnt) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (wpcir) begin
                        state_d = S_REQ;
                    end else begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (wpcir) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        // Request is a registered decode of the next state, so it is low
        // during reset and rises on the first clock after release.
        req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_REQ;
            req_q        <= 1'b0;
            pc_q         <= RESET_PC;
            dpc4_q       <= 32'h0;
            inst_q       <= 32'h0;
            dvalid_q     <= 1'b0;
            hold_q       <= 32'h0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            pc_q         <= pc_d;
            dpc4_q       <= dpc4_d;
            inst_q       <= inst_d;
            dvalid_q     <= dvalid_d;
            hold_q       <= hold_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dpc4      = dpc4_q;
    assign inst      = inst_q;
    assign dvalid    = dvalid_q;

endmodule

// File: tb/tb_pipe_fetch.sv
// tb/tb_pipe_fetch.sv - directed self-checking bench for pipe_fetch

module tb_pipe_fetch;

    logic        clock;
    logic        resetn;
    logic [1:0]  pcsource;
    logic [31:0] bpc;
    logic [31:0] jpc;
    logic [31:0] da;
    logic        wpcir;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] dpc4;
    logic [31:0] inst;
    logic        dvalid;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .pcsource    (pcsource),
        .bpc         (bpc),
        .jpc         (jpc),
        .da          (da),
        .wpcir       (wpcir),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .dpc4        (dpc4),
        .inst        (inst),
        .dvalid      (dvalid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: word at address a is ~a; response arrives rdelay cycles
    // after the grant. Every handshake address is logged.
    logic        busy;
    int          cnt;
    int          rdelay;
    logic [31:0] lat_addr;
    logic [31:0] hs_log [$];

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            busy     <= 1'b0;
            cnt      <= 0;
            lat_addr <= 32'h0;
        end else if (imem_req && imem_gnt) begin
            busy     <= 1'b1;
            cnt      <= rdelay;
            lat_addr <= imem_addr;
            hs_log.push_back(imem_addr);
        end else if (busy) begin
            if (cnt == 1) busy <= 1'b0;
            else          cnt  <= cnt - 1;
        end
    end

    assign imem_rvalid = busy && (cnt == 1);
    assign imem_rdata  = imem_rvalid ? ~lat_addr : 32'h0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_inst,
                            input logic [31:0] e_dpc4, input logic e_dvalid);
        chk32({tag, "_inst"}, inst, e_inst);
        chk32({tag, "_dpc4"}, dpc4, e_dpc4);
        chk1({tag, "_dvalid"}, dvalid, e_dvalid);
    endtask

    logic [31:0] exp_log [14];

    initial begin
        exp_log = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h204,
                    32'h100, 32'h104, 32'h108, 32'h400, 32'h404,
                    32'h3FC, 32'h400, 32'hFFFF_FFFC, 32'h0};
        resetn   = 1'b1;
        pcsource = 2'b00;
        bpc      = 32'h0;
        jpc      = 32'h0;
        da       = 32'h0;
        wpcir    = 1'b1;
        imem_gnt = 1'b1;
        rdelay   = 1;
        #3 resetn = 1'b0;
        #1;
        chk32("rst_pc", pc, 32'h100);
        chk1("rst_req", imem_req, 1'b0);
        chk_ifid("rst", 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        #1;
        chk32("c0_addr", imem_addr, 32'h100);

        // Sequential fetch of A (0x100) and B (0x104)
        tick; chk1("e1_req", imem_req, 1'b1); chk32("e1_addr", imem_addr, 32'h100);
        tick; chk1("e2_req", imem_req, 1'b0); chk_ifid("e2_bub", 32'h0, 32'h0, 1'b0);
        tick; chk_ifid("e3_A", 32'hFFFF_FEFF, 32'h104, 1'b1);
              chk32("e3_pc", pc, 32'h104); chk1("e3_req", imem_req, 1'b1);
        wpcir = 1'b0;

        // Stall for three cycles while 0x104 is in flight
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_ifid("stall", 32'hFFFF_FEFF, 32'h104, 1'b1);
            chk32("stall_pc", pc, 32'h104);
            chk1("stall_req", imem_req, 1'b0);
        end
        wpcir = 1'b1;
        tick; chk_ifid("e7_B", 32'hFFFF_FEFB, 32'h108, 1'b1); chk32("e7_pc", pc, 32'h108);

        // Branch in decode on the cycle the delay slot 0x108 is delivered
        tick; chk_ifid("e8_bub", 32'h0, 32'h108, 1'b0);
        pcsource = 2'b01; bpc = 32'h200;
        tick; chk_ifid("e9_ds", 32'hFFFF_FEF7, 32'h10C, 1'b1);
              chk32("e9_addr", imem_addr, 32'h200);
        pcsource = 2'b00;
        tick; chk1("e10_req", imem_req, 1'b0);
        tick; chk_ifid("e11", 32'hFFFF_FDFF, 32'h204, 1'b1); chk32("e11_pc", pc, 32'h204);

        // Reset pulsed while 0x204 is in S_WAIT
        tick; chk1("e12_req", imem_req, 1'b0);
        #1 resetn = 1'b0;
        #1;
        chk32("mid_rst_pc", pc, 32'h100);
        chk1("mid_rst_req", imem_req, 1'b0);
        chk_ifid("mid_rst", 32'h0, 32'h0, 1'b0);
        @(negedge clock);
        resetn = 1'b1;

        // Restart with one cycle of withheld grant
        tick; chk1("r1_req", imem_req, 1'b1);
        imem_gnt = 1'b0;
        tick; chk1("nogrant_req", imem_req, 1'b1); chk32("nogrant_pc", pc, 32'h100);
        imem_gnt = 1'b1;
        tick;
        tick; chk_ifid("r_A", 32'hFFFF_FEFF, 32'h104, 1'b1);
        tick;
        tick; chk32("r_pc108", pc, 32'h108);
        rdelay = 4;

        // Jump taken while the delay-slot fetch of 0x108 is slow
        tick;
        pcsource = 2'b11; jpc = 32'h400;
        tick; pcsource = 2'b00;
              chk32("slow_pc", pc, 32'h108); chk1("slow_req", imem_req, 1'b0);
              chk_ifid("slow_bub1", 32'h0, 32'h108, 1'b0);
        tick; chk_ifid("slow_bub2", 32'h0, 32'h108, 1'b0);
        tick; chk_ifid("slow_bub3", 32'h0, 32'h108, 1'b0);
        tick; chk_ifid("slow_ds", 32'hFFFF_FEF7, 32'h10C, 1'b1);
              chk32("slow_pc400", pc, 32'h400);
        rdelay = 1;
        tick;
        tick; chk_ifid("j400", 32'hFFFF_FBFF, 32'h404, 1'b1); chk32("j400_pc", pc, 32'h404);

        // jr to 0x3FC raised before the delay slot fetch has even started
        pcsource = 2'b10; da = 32'h3FC;
        tick; pcsource = 2'b00; chk32("jr_pend_pc", pc, 32'h404);
        tick; chk_ifid("jr_ds", 32'hFFFF_FBFB, 32'h408, 1'b1); chk32("jr_pc", pc, 32'h3FC);
        tick;
        tick; chk_ifid("jr_tgt", 32'hFFFF_FC03, 32'h400, 1'b1); chk32("seq_pc", pc, 32'h400);
        tick;
        pcsource = 2'b10; da = 32'hFFFF_FFFC;
        tick; pcsource = 2'b00; chk32("wrap_pc", pc, 32'hFFFF_FFFC);
        tick;
        tick; chk_ifid("wrap", 32'h0000_0003, 32'h0, 1'b1); chk32("wrap_pc0", pc, 32'h0);
        tick; chk1("wrap_req", imem_req, 1'b0);

        // Full request history, which must never contain 0x10C
        chk32("log_size", hs_log.size(), 32'd14);
        for (int i = 0; i < 14; i++) begin
            if (i < hs_log.size()) chk32($sformatf("log%0d", i), hs_log[i], exp_log[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
